// File: rtl/nios_dip_debounce_pkg.sv
// nios_dip_debounce_pkg: board I/O constants shared by the DIP-switch conditioning stage
package nios_dip_debounce_pkg;
  localparam int DIP_WIDTH = 4;
  localparam int CLK_HZ = 50_000_000;
  localparam int DEBOUNCE_MS = 1;
  localparam int DIP_DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/nios_debounce_bit.sv
// nios_debounce_bit: one synchroniser chain, qualification counter, clean level and edge pulses
module nios_debounce_bit
  import nios_dip_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DIP_DEBOUNCE_CYCLES,
  parameter logic RST             = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic debounced,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= {SYNC_STAGES{RST}};
    else sync <= {sync[SYNC_STAGES-2:0], raw};
  // Any sample matching the clean level restarts qualification from zero
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      debounced <= RST;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == debounced) cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        debounced <= s;
        rise <= s;
        fall <= ~s;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/nios_dip_debounce.sv
// nios_dip_debounce: synchronise and debounce the DIP-switch pins feeding the PIO in_port
module nios_dip_debounce
  import nios_dip_debounce_pkg::*;
#(
  parameter int               WIDTH           = DIP_WIDTH,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DIP_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    nios_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST(RESET_VALUE[g])
    ) u_bit (
      .clk(clk),
      .reset_n(reset_n),
      .raw(raw_in[g]),
      .debounced(debounced[g]),
      .rise(rise[g]),
      .fall(fall[g])
    );
  end
  assign changed = |{rise, fall};
endmodule
